// File: rtl/riscv_pkg.sv
// Shared RV32I constants and small helpers used across the core front end.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [ILEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_INC           = 32'd4;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush and occupancy count; storage is not reset,
// only the pointers and count are.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/instr_fetch.sv
// RV32I fetch stage: PC register, credit-limited in-order imem requests,
// {instr,pc} buffer to decode, and redirect handling with stale-word dropping.
module instr_fetch
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ILEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = ILEN + XLEN;
  localparam logic [CW:0] DEPTH_LIM = (CW + 1)'(FIFO_DEPTH);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic            accept, keep_rsp, buf_pop, credit_ok;
  logic [CW-1:0]   buf_count, pcq_count;
  logic            buf_empty, buf_full, pcq_empty, pcq_full;
  logic [BW-1:0]   buf_head;
  logic [XLEN-1:0] rsp_pc;

  // Words in the buffer plus words in flight may never exceed the buffer size,
  // so every response has a guaranteed slot.
  assign credit_ok      = ({1'b0, buf_count} + {1'b0, outstanding_q}) < DEPTH_LIM;
  assign imem_req_valid = rst_n && !redirect_valid && credit_ok;
  assign imem_req_addr  = pc_q;
  assign accept         = imem_req_valid && imem_req_ready;
  assign keep_rsp       = imem_rsp_valid && (drop_q == '0) && !redirect_valid;
  assign buf_pop        = out_valid && out_ready && !redirect_valid;

  assign out_valid = rst_n && !buf_empty;
  assign out_instr = out_valid ? buf_head[BW-1 -: ILEN] : '0;
  assign out_pc    = out_valid ? buf_head[XLEN-1:0]     : '0;

  always_comb begin
    pc_d          = pc_q;
    drop_d        = drop_q;
    outstanding_d = outstanding_q + CW'(accept) - CW'(imem_rsp_valid);
    if (accept) pc_d = pc_q + PC_INC;
    // Everything still in flight after this cycle belongs to the old path.
    if (redirect_valid) begin
      pc_d   = word_align(redirect_pc);
      drop_d = outstanding_q - CW'(imem_rsp_valid);
    end else if (imem_rsp_valid && (drop_q != '0)) begin
      drop_d = drop_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  fetch_fifo #(.WIDTH(XLEN), .DEPTH(FIFO_DEPTH)) u_pc_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept),
    .pop   (imem_rsp_valid),
    .flush (1'b0),
    .din   (pc_q),
    .dout  (rsp_pc),
    .empty (pcq_empty),
    .full  (pcq_full),
    .count (pcq_count)
  );

  fetch_fifo #(.WIDTH(BW), .DEPTH(FIFO_DEPTH)) u_instr_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (keep_rsp),
    .pop   (buf_pop),
    .flush (redirect_valid),
    .din   ({imem_rsp_data, rsp_pc}),
    .dout  (buf_head),
    .empty (buf_empty),
    .full  (buf_full),
    .count (buf_count)
  );

  a_rsp_legal: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> (outstanding_q != '0) && !pcq_empty);
  a_pcq_tracks: assert property (@(posedge clk) disable iff (!rst_n)
    pcq_count == outstanding_q);
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(keep_rsp && buf_full && !buf_pop) && !(accept && pcq_full));

endmodule
